// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider (div/divu) with an IDLE/BUSY/DONE FSM.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor bypasses the iterations and completes in one cycle.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_divisor;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_q_neg;
    logic        r_r_neg;

    logic        w_accept;
    logic        w_zero_fast;
    logic [31:0] w_a_abs;
    logic [31:0] w_b_abs;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_next;
    logic [31:0] w_lo_fin;
    logic [31:0] w_hi_fin;

    assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;

`ifdef DIV_ZERO_FAST_EN
    assign w_zero_fast = (b_i == 32'd0);
`else
    assign w_zero_fast = 1'b0;
`endif

    // Magnitudes; unsigned operands pass through untouched.
    assign w_a_abs = (signed_i && a_i[31]) ? (32'd0 - a_i) : a_i;
    assign w_b_abs = (signed_i && b_i[31]) ? (32'd0 - b_i) : b_i;

    // The shifted remainder is always below twice the divisor, so bit 32 of the
    // 33-bit difference is set exactly when the trial subtraction went negative.
    assign w_shift     = {r_rem, r_quot[31]};
    assign w_diff      = w_shift - {1'b0, r_divisor};
    assign w_ge        = ~w_diff[32];
    assign w_rem_next  = w_ge ? w_diff[31:0] : w_shift[31:0];
    assign w_quot_next = {r_quot[30:0], w_ge};
    assign w_lo_fin    = r_q_neg ? (32'd0 - w_quot_next) : w_quot_next;
    assign w_hi_fin    = r_r_neg ? (32'd0 - w_rem_next) : w_rem_next;

    assign stall_o = !rst && (w_accept || ((r_state == S_BUSY) && !annul_i));
    assign valid_o = !rst && (r_state == S_DONE) && !annul_i;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

    // FSM, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_divisor <= 32'd0;
            r_rem     <= 32'd0;
            r_quot    <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_zero_fast) begin
                        r_lo    <= 32'hFFFF_FFFF;
                        r_hi    <= a_i;
                        r_state <= S_DONE;
                    end else if (w_accept) begin
                        r_divisor <= w_b_abs;
                        r_quot    <= w_a_abs;
                        r_rem     <= 32'd0;
                        r_cnt     <= 6'd0;
                        r_q_neg   <= (a_i[31] ^ b_i[31]) & signed_i;
                        r_r_neg   <= a_i[31] & signed_i;
                        r_state   <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + 6'd1;
                        if (r_cnt == 6'd31) begin
                            r_lo    <= w_lo_fin;
                            r_hi    <= w_hi_fin;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
